serial_deser: RTL and testbench

//  Parametrised serial-to-parallel deserialiser, successor to the fixed 8-bit shifter.

---
 rtl/serial_deser.sv | 82 ++++++++
 tb/tb_serial_deser.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_deser.sv
// Serial-to-parallel deserialiser: frames WIDTH-bit words from a gated bit stream and
// presents each completed word through a valid/ready holding register with overrun flag.
module serial_deser #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                     clk_50,
   input  logic                     reset,
   input  logic                     serial_data,
   input  logic                     data_ena,
   input  logic                     clear,
   input  logic                     word_ready,
   output logic [WIDTH-1:0]         word_out,
   output logic                     word_valid,
   output logic [$clog2(WIDTH)-1:0] bit_count,
   output logic                     overrun
);

   localparam int CW = $clog2(WIDTH);

   // Handshake: a word transfers on every clk_50 edge where word_valid and word_ready are
   // both high; word_out/word_valid hold steady while word_valid=1 and word_ready=0.

   logic [WIDTH-1:0] r_sh;
   logic [CW-1:0]    r_bit_count;
   logic [WIDTH-1:0] r_word_out;
   logic             r_word_valid;
   logic             r_overrun;

   logic [WIDTH-1:0] w_shifted;
   logic             w_last;
   logic             w_complete;
   logic             w_accept;
   logic             w_slot_free;

   always_comb begin
      w_shifted = r_sh;
      if (LSB_FIRST) w_shifted = {serial_data, r_sh[WIDTH-1:1]};
      else           w_shifted = {r_sh[WIDTH-2:0], serial_data};
   end

   assign w_last      = (r_bit_count == CW'(WIDTH-1));
   // clear discards the bit on the wire, so it also suppresses completion
   assign w_complete  = data_ena & ~clear & w_last;
   assign w_accept    = r_word_valid & word_ready;
   assign w_slot_free = ~r_word_valid | word_ready;

   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_sh         <= '0;
         r_bit_count  <= '0;
         r_word_out   <= '0;
         r_word_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (clear) begin
            r_sh        <= '0;
            r_bit_count <= '0;
            r_overrun   <= 1'b0;
         end else if (data_ena) begin
            r_sh        <= w_shifted;
            r_bit_count <= w_last ? '0 : r_bit_count + CW'(1);
         end

         // A completion into a freed slot keeps word_valid high: back-to-back, no bubble
         if (w_complete && w_slot_free) begin
            r_word_out   <= w_shifted;
            r_word_valid <= 1'b1;
         end else if (w_complete) begin
            r_overrun    <= 1'b1;
         end else if (w_accept) begin
            r_word_valid <= 1'b0;
         end
      end
   end

   assign word_out   = r_word_out;
   assign word_valid = r_word_valid;
   assign bit_count  = r_bit_count;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: two instances (LSB-first and MSB-first) share one stimulus stream;
// a bit-list reference model feeds per-instance expected-word queues popped on each accept.
module tb_serial_deser;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk_50 = 1'b0;
  logic          reset = 1'b1;
  logic          serial_data = 1'b0;
  logic          data_ena = 1'b0;
  logic          clear = 1'b0;
  logic          word_ready = 1'b0;
  logic [W-1:0]  wo_l, wo_m;
  logic          wv_l, wv_m;
  logic [CW-1:0] bc_l, bc_m;
  logic          ov_l, ov_m;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic         m_bits[$];
  logic         m_valid;
  logic [W-1:0] m_word_l, m_word_m;
  logic         m_ovr;
  logic [W-1:0] exp_q_l[$];
  logic [W-1:0] exp_q_m[$];

  // clock/reset block
  always #10 clk_50 = ~clk_50;

  serial_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk_50(clk_50), .reset(reset), .serial_data(serial_data), .data_ena(data_ena),
    .clear(clear), .word_ready(word_ready), .word_out(wo_l), .word_valid(wv_l),
    .bit_count(bc_l), .overrun(ov_l));

  serial_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk_50(clk_50), .reset(reset), .serial_data(serial_data), .data_ena(data_ena),
    .clear(clear), .word_ready(word_ready), .word_out(wo_m), .word_valid(wv_m),
    .bit_count(bc_m), .overrun(ov_m));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: one clock edge with the given inputs
  task automatic model_edge(input logic rst, sd, en, clr, rdy);
    logic [W-1:0] wl, wm;
    logic         acc;
    acc = m_valid && rdy;
    if (rst) begin
      m_bits.delete();
      m_valid = 0; m_word_l = '0; m_word_m = '0; m_ovr = 0;
      exp_q_l.delete(); exp_q_m.delete();
    end else if (clr) begin
      m_bits.delete();
      m_ovr = 0;
      if (acc) m_valid = 0;
    end else if (en && m_bits.size() == W-1) begin
      m_bits.push_back(sd);
      wl = '0; wm = '0;
      for (int i = 0; i < W; i++) begin
        wl = wl | (W'(m_bits[i]) << i);
        wm = wm | (W'(m_bits[i]) << (W-1-i));
      end
      m_bits.delete();
      if (!m_valid || rdy) begin
        m_word_l = wl; m_word_m = wm; m_valid = 1;
        exp_q_l.push_back(wl); exp_q_m.push_back(wm);
      end else begin
        m_ovr = 1;
      end
    end else begin
      if (en) m_bits.push_back(sd);
      if (acc) m_valid = 0;
    end
  endtask

  // driver: apply inputs for one cycle, then compare the state after the edge
  task automatic step(input logic rst, sd, en, clr, rdy);
    reset = rst; serial_data = sd; data_ena = en; clear = clr; word_ready = rdy;
    model_edge(rst, sd, en, clr, rdy);
    @(posedge clk_50);
    #1;
    check("bit_count_l", 32'(bc_l), 32'(m_bits.size()));
    check("bit_count_m", 32'(bc_m), 32'(m_bits.size()));
    check("valid_l", 32'(wv_l), 32'(m_valid));
    check("valid_m", 32'(wv_m), 32'(m_valid));
    check("overrun_l", 32'(ov_l), 32'(m_ovr));
    check("overrun_m", 32'(ov_m), 32'(m_ovr));
    check("word_hold_l", 32'(wo_l), 32'(m_word_l));
    check("word_hold_m", 32'(wo_m), 32'(m_word_m));
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy);
  endtask

  // sends v[0] first; gap idle cycles after each bit; ready for the last bit may differ
  task automatic send_word(input logic [W-1:0] v, input int gap, input logic rdy,
                           input logic rdy_last);
    for (int i = 0; i < W; i++) begin
      step(0, v[i], 1, 0, (i == W-1) ? rdy_last : rdy);
      if (i < W-1) idle(rdy, gap);
    end
  endtask

  // scoreboard monitor: pop on every accepted transfer
  always @(negedge clk_50) begin
    if (!reset && wv_l && word_ready) begin
      if (exp_q_l.size() == 0) check("accept_unexpected_l", 32'(wo_l), 32'hFFFF_FFFF);
      else check("accept_word_l", 32'(wo_l), 32'(exp_q_l.pop_front()));
    end
    if (!reset && wv_m && word_ready) begin
      if (exp_q_m.size() == 0) check("accept_unexpected_m", 32'(wo_m), 32'hFFFF_FFFF);
      else check("accept_word_m", 32'(wo_m), 32'(exp_q_m.pop_front()));
    end
  end

  initial begin
    logic [W-1:0] stream;
    stream = 8'h4D;  // bits 1,0,1,1,0,0,1,0 in arrival order

    // reset with data_ena toggling, then reset mid-word
    m_valid = 0; m_ovr = 0; m_word_l = '0; m_word_m = '0;
    for (int i = 0; i < 4; i++) step(1, 1, i[0], 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1);
    check("bits_before_reset", 32'(bc_l), 32'd4);
    step(1, 1, 1, 0, 1);
    check("bits_after_reset", 32'(bc_l), 32'd0);

    // basic framing, ready held high
    send_word(stream, 0, 1, 1);
    check("dir_lsb_4d", 32'(wo_l), 32'h4D);
    check("dir_msb_b2", 32'(wo_m), 32'hB2);
    check("dir_valid", 32'(wv_l), 32'd1);
    idle(1, 1);
    check("dir_valid_one_cycle", 32'(wv_l), 32'd0);

    // gapped data_ena
    send_word(stream, 2, 1, 1);
    check("dir_gapped_4d", 32'(wo_l), 32'h4D);
    idle(1, 2);

    // backpressure and overrun
    send_word(8'hA5, 0, 0, 0);
    send_word(8'h3C, 0, 0, 0);
    check("dir_hold_a5", 32'(wo_l), 32'hA5);
    check("dir_overrun", 32'(ov_l), 32'd1);
    idle(1, 1);
    check("dir_overrun_sticky", 32'(ov_l), 32'd1);
    step(0, 0, 0, 1, 0);
    check("dir_overrun_cleared", 32'(ov_l), 32'd0);

    // back-to-back accept with completion
    send_word(8'h11, 0, 0, 0);
    send_word(8'h3C, 0, 0, 1);
    check("dir_b2b_3c", 32'(wo_l), 32'h3C);
    check("dir_b2b_valid", 32'(wv_l), 32'd1);
    check("dir_b2b_no_overrun", 32'(ov_l), 32'd0);
    idle(1, 1);

    // resync: 3 bits, clear with data_ena, then 8'h5A; pending word survives a clear
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    send_word(8'h5A, 0, 0, 0);
    check("dir_resync_5a", 32'(wo_l), 32'h5A);
    step(0, 1, 1, 1, 0);
    check("dir_valid_across_clear", 32'(wv_l), 32'd1);
    idle(1, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 2) != 0);
    end

    // drain
    idle(1, 3);
    check("drain_q_l", 32'(exp_q_l.size()), 32'd0);
    check("drain_q_m", 32'(exp_q_m.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
